regfile_writeback: RTL

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback.sv | 127 ++++++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// Writeback stage: queues register-file writes in a FIFO and retires one per cycle.
// `WORD is normally supplied by definitions.vh (64 if absent); define WB_BYPASS_EN for the lookup port.
`ifndef WORD
`define WORD 64
`endif

module regfile_writeback #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_reg_write,
    input  logic               in_mem_to_reg,
    input  logic [4:0]         in_rd,
    input  logic [`WORD-1:0]   alu_result,
    input  logic [`WORD-1:0]   mem_data,
    output logic [4:0]         write_register,
    output logic [`WORD-1:0]   write_data,
    output logic               reg_write,
    output logic               busy,
    output logic [15:0]        commit_count
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]         lookup_rd,
    output logic               lookup_hit,
    output logic [`WORD-1:0]   lookup_data
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [4:0] XZR = 5'd31;

    logic [4:0]         r_mem_rd   [DEPTH];
    logic [`WORD-1:0]   r_mem_data [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic [4:0]         r_write_register;
    logic [`WORD-1:0]   r_write_data;
    logic               r_reg_write;
    logic [15:0]        r_commit_count;

    logic               w_transfer;
    logic               w_enq;
    logic               w_pop;
    logic [`WORD-1:0]   w_data;

    assign in_ready   = (r_count < CNT_W'(DEPTH));
    assign w_transfer = in_valid && in_ready;
    assign w_enq      = w_transfer && in_reg_write && (in_rd != XZR);
    assign w_pop      = (r_count != '0);
    assign w_data     = in_mem_to_reg ? mem_data : alu_result;

    assign write_register = r_write_register;
    assign write_data     = r_write_data;
    assign reg_write      = r_reg_write;
    assign commit_count   = r_commit_count;
    assign busy           = (r_count != '0) || r_reg_write;

    // Storage carries no reset: only the pointers/occupancy define validity.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem_rd[r_wptr]   <= in_rd;
            r_mem_data[r_wptr] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr           <= '0;
            r_rptr           <= '0;
            r_count          <= '0;
            r_write_register <= '0;
            r_write_data     <= '0;
            r_reg_write      <= 1'b0;
            r_commit_count   <= '0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_write_register <= r_mem_rd[r_rptr];
                r_write_data     <= r_mem_data[r_rptr];
                r_reg_write      <= 1'b1;
                r_commit_count   <= r_commit_count + 16'd1;
                r_rptr           <= r_rptr + PTR_W'(1);
            end else begin
                r_reg_write      <= 1'b0;
            end
        end
    end

`ifdef WB_BYPASS_EN
    logic [PTR_W-1:0] w_lk_idx;

    // Scan oldest to youngest so the youngest pending match wins over older ones and the output stage.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        w_lk_idx    = '0;
        if (r_reg_write && (r_write_register == lookup_rd)) begin
            lookup_hit  = 1'b1;
            lookup_data = r_write_data;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_lk_idx = r_rptr + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_mem_rd[w_lk_idx] == lookup_rd)) begin
                lookup_hit  = 1'b1;
                lookup_data = r_mem_data[w_lk_idx];
            end
        end
        if (lookup_rd == XZR) begin
            lookup_hit  = 1'b0;
            lookup_data = '0;
        end
    end
`endif

endmodule
